// File: rtl/reveal_ctrl_pkg.sv
// Shared definitions for the minesweeper reveal controller: FSM encoding,
// cell_val field positions and the 8-neighbour offset table.
package reveal_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_POP   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_EVAL  = 3'd3,
        ST_NEIGH = 3'd4,
        ST_END   = 3'd5
    } state_t;

    localparam int MINE_BIT  = 4;
    localparam int COUNT_MSB = 3;

    // Neighbour k=0..7 walks the 3x3 ring row by row, skipping the centre.
    function automatic logic signed [1:0] nb_dx(input logic [2:0] k);
        case (k)
            3'd0, 3'd3, 3'd5: return -2'sd1;
            3'd1, 3'd6:       return 2'sd0;
            default:          return 2'sd1;
        endcase
    endfunction

    function automatic logic signed [1:0] nb_dy(input logic [2:0] k);
        case (k)
            3'd0, 3'd1, 3'd2: return -2'sd1;
            3'd3, 3'd4:       return 2'sd0;
            default:          return 2'sd1;
        endcase
    endfunction

endpackage

// File: rtl/reveal_fifo.sv
// Work queue of packed {y,x} cells awaiting evaluation; head is visible
// combinationally so a pop and its data arrive in the same cycle.
module reveal_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 256
)(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    input  logic             i_flush,
    output logic [WIDTH-1:0] o_head,
    output logic             o_empty,
    output logic             o_full
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == (PW+1)'(DEPTH));
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge i_clk) begin
        if (w_do_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/reveal_ctrl.sv
// Flood-fill reveal controller: owns the revealed bitmap, walks zero-count
// cells through a work FIFO, and flags loss/win.
module reveal_ctrl
    import reveal_ctrl_pkg::*;
#(
    parameter int X_SIZE       = 16,
    parameter int Y_SIZE       = 16,
    parameter int X_COORD_BITS = 4,
    parameter int Y_COORD_BITS = 4
)(
    input  logic                                 i_clk,
    input  logic                                 i_rst_n,
    input  logic                                 i_new_game,
    input  logic                                 i_reveal_req,
    input  logic [X_COORD_BITS-1:0]              i_sel_x,
    input  logic [Y_COORD_BITS-1:0]              i_sel_y,
    input  logic                                 i_is_init,
    input  logic [X_COORD_BITS+Y_COORD_BITS-1:0] i_num_mines,
    input  logic [4:0]                           i_cell_val,
    output logic [X_COORD_BITS-1:0]              o_x_coord,
    output logic [Y_COORD_BITS-1:0]              o_y_coord,
    input  logic [X_COORD_BITS-1:0]              i_disp_x,
    input  logic [Y_COORD_BITS-1:0]              i_disp_y,
    output logic                                 o_disp_revealed,
    output logic                                 o_busy,
    output logic [X_COORD_BITS+Y_COORD_BITS:0]   o_revealed_cnt,
    output logic                                 o_game_over,
    output logic                                 o_game_won
);
    localparam int CELLS = X_SIZE * Y_SIZE;
    localparam int AW    = X_COORD_BITS + Y_COORD_BITS;
    localparam int CW    = AW + 1;
    localparam int IW    = (CELLS > 1) ? $clog2(CELLS) : 1;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [CELLS-1:0]        r_revealed;
    logic [X_COORD_BITS-1:0] r_cur_x;
    logic [Y_COORD_BITS-1:0] r_cur_y;
    logic [2:0]              r_k;
    logic [CW-1:0]           r_cnt;
    logic                    r_game_over;
    logic                    r_game_won;

    logic                    w_push;
    logic                    w_pop;
    logic                    w_flush;
    logic [AW-1:0]           w_push_data;
    logic [IW-1:0]           w_push_idx;
    logic [AW-1:0]           w_fifo_head;
    logic                    w_fifo_empty;
    logic                    w_fifo_full;
    logic                    w_accept;
    logic                    w_clear;
    logic                    w_is_mine;
    logic                    w_count_zero;
    logic                    w_nb_in;
    logic                    w_nb_push;
    logic [X_COORD_BITS-1:0] w_nb_x;
    logic [Y_COORD_BITS-1:0] w_nb_y;
    logic [CW-1:0]           w_win_target;

    function automatic logic [IW-1:0] cell_idx(input logic [X_COORD_BITS-1:0] x,
                                               input logic [Y_COORD_BITS-1:0] y);
        return IW'(int'(y) * X_SIZE + int'(x));
    endfunction

    // Signed arithmetic in int so edge cells never wrap to the far side.
    always_comb begin
        int nx;
        int ny;
        nx      = int'(r_cur_x) + int'(nb_dx(r_k));
        ny      = int'(r_cur_y) + int'(nb_dy(r_k));
        w_nb_in = (nx >= 0) && (nx < X_SIZE) && (ny >= 0) && (ny < Y_SIZE);
        w_nb_x  = X_COORD_BITS'(nx);
        w_nb_y  = Y_COORD_BITS'(ny);
    end

    assign w_nb_push    = (r_state == ST_NEIGH) && w_nb_in && !r_revealed[cell_idx(w_nb_x, w_nb_y)];
    assign w_clear      = (r_state == ST_IDLE) && i_new_game;
    assign w_accept     = (r_state == ST_IDLE) && i_reveal_req && !i_new_game && i_is_init &&
                          !r_game_over && !r_game_won && !r_revealed[cell_idx(i_sel_x, i_sel_y)];
    assign w_is_mine    = i_cell_val[MINE_BIT];
    assign w_count_zero = (i_cell_val[COUNT_MSB:0] == '0);
    assign w_win_target = CW'(CELLS) - CW'(i_num_mines);
    assign w_push_idx   = cell_idx(w_push_data[X_COORD_BITS-1:0], w_push_data[AW-1:X_COORD_BITS]);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= ST_IDLE;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept) w_state_next = ST_POP;
            ST_POP:   w_state_next = ST_WAIT;
            ST_WAIT:  w_state_next = ST_EVAL;
            ST_EVAL: begin
                if (w_is_mine)          w_state_next = ST_END;
                else if (!w_count_zero) w_state_next = w_fifo_empty ? ST_END : ST_POP;
                else                    w_state_next = ST_NEIGH;
            end
            // The last neighbour's own push must count toward "non-empty".
            ST_NEIGH: if (r_k == 3'd7) w_state_next = (w_fifo_empty && !w_push) ? ST_END : ST_POP;
            ST_END:   w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_push      = 1'b0;
        w_push_data = '0;
        w_pop       = 1'b0;
        w_flush     = w_clear;
        case (r_state)
            ST_IDLE: begin
                w_push      = w_accept;
                w_push_data = {i_sel_y, i_sel_x};
            end
            ST_POP:  w_pop = 1'b1;
            ST_EVAL: if (w_is_mine) w_flush = 1'b1;
            ST_NEIGH: begin
                w_push      = w_nb_push;
                w_push_data = {w_nb_y, w_nb_x};
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_revealed  <= '0;
            r_cnt       <= '0;
            r_cur_x     <= '0;
            r_cur_y     <= '0;
            r_k         <= '0;
            r_game_over <= 1'b0;
            r_game_won  <= 1'b0;
        end else begin
            if (w_clear) begin
                r_revealed  <= '0;
                r_cnt       <= '0;
                r_game_over <= 1'b0;
                r_game_won  <= 1'b0;
            end else if (w_push) begin
                r_revealed[w_push_idx] <= 1'b1;
                r_cnt                  <= r_cnt + CW'(1);
            end
            case (r_state)
                ST_POP:   {r_cur_y, r_cur_x} <= w_fifo_head;
                ST_EVAL: begin
                    r_k <= '0;
                    if (w_is_mine) r_game_over <= 1'b1;
                end
                ST_NEIGH: r_k <= r_k + 3'd1;
                ST_END:   if (!r_game_over && r_cnt == w_win_target) r_game_won <= 1'b1;
                default: ;
            endcase
        end
    end

    reveal_fifo #(
        .WIDTH (AW),
        .DEPTH (CELLS)
    ) u_fifo (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .i_flush     (w_flush),
        .o_head      (w_fifo_head),
        .o_empty     (w_fifo_empty),
        .o_full      (w_fifo_full)
    );

    assign o_x_coord       = r_cur_x;
    assign o_y_coord       = r_cur_y;
    assign o_disp_revealed = r_revealed[cell_idx(i_disp_x, i_disp_y)];
    assign o_busy          = (r_state != ST_IDLE);
    assign o_revealed_cnt  = r_cnt;
    assign o_game_over     = r_game_over;
    assign o_game_won      = r_game_won;

endmodule
